// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, error codes and FSM states for the 7-segment scan path
package seg7_pkg;
  // Active-low patterns a..g on bits 0..6, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_ENABLE  = 2'b10;
  typedef enum logic {SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: reverse lookup of an active-low segment pattern to its hex nibble
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_digit,
  output logic       is_blank
);
  // Search the shared encoder table; patterns are unique so at most one hits.
  always_comb begin
    nibble   = '0;
    is_digit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg == SEG_PAT[k]) begin
        nibble   = 4'(k);
        is_digit = 1'b1;
      end
    end
  end
  assign is_blank = seg == SEG_BLANK;
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment bus and reassembles the displayed hex word
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [6:0]                              seg_in,
  input  logic [DIGITS-1:0]                       an_in,
  output logic [4*DIGITS-1:0]                     word_out,
  output logic                                    word_valid,
  output logic                                    err_pulse,
  output logic [1:0]                              err_code,
  output logic [(DIGITS>1?$clog2(DIGITS):1)-1:0]  err_digit,
  output logic                                    busy
);
  localparam int W  = 7 + DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] word_out_q, word_out_d;
  logic word_valid_q, word_valid_d, err_pulse_q, err_pulse_d;
  logic [1:0] err_code_q, err_code_d;
  logic [IW-1:0] err_digit_q, err_digit_d, idx;
  logic accept;
  logic [3:0] nibble;
  logic is_digit, is_blank;
  wire [DIGITS-1:0] an_s  = sync2_q[DIGITS-1:0];
  wire [6:0]        seg_s = sync2_q[W-1:DIGITS];
  wire              diff  = sync2_q != prev_q;
  seg7_to_hex u_lookup (.seg(seg_s), .nibble(nibble), .is_digit(is_digit), .is_blank(is_blank));
  // Settle/hold FSM, accept classification and frame completion.
  always_comb begin
    sync1_d      = {seg_in, an_in};
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_digit_d  = err_digit_q;
    accept       = 1'b0;
    idx          = '0;
    for (int k = 0; k < DIGITS; k++) if (!an_s[k]) idx = IW'(k);
    if (state_q == SETTLE) begin
      if (diff) cnt_d = '0;
      else if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
        accept  = 1'b1;
        state_d = HOLD;
      end else cnt_d = cnt_q + 8'd1;
    end else if (diff) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end
    if (accept && !(&an_s)) begin
      if (!$onehot(~an_s)) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_ENABLE;
        err_digit_d = '0;
        mask_d      = '0;
      end else if (is_digit) begin
        shadow_d[idx] = nibble;
        mask_d[idx]   = 1'b1;
      end else if (!is_blank) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_PATTERN;
        err_digit_d = idx;
        mask_d      = '0;
      end
    end
    if (&mask_d) begin
      word_out_d   = shadow_d;
      word_valid_d = 1'b1;
      mask_d       = '0;
    end
  end
  // State registers; synchronizers reset to the idle all-ones level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      cnt_q        <= '0;
      state_q      <= SETTLE;
      mask_q       <= '0;
      shadow_q     <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_digit_q  <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_digit_q  <= err_digit_d;
    end
  end
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_digit  = err_digit_q;
  assign busy       = |mask_q;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader side of the multiplexed 7-segment display bus; the inverse of the hex-to-segment encoder.
- Samples the active-low segment and active-low digit-enable lines, waits for each digit pattern to settle, and decodes each pattern back to a hex nibble.
- Assembles a full DIGITS-nibble word and flags illegal patterns or illegal enables.
- Used for on-board self-check of the HACK PC display path and for loopback of display pins.

Parameters:
- DIGITS, 4: number of multiplexed digits; also the width of an_in. The word is 4*DIGITS bits.
- STABLE_CYCLES, 8: consecutive identical synchronized samples needed before a digit is accepted. Legal range is 2..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  segments, active-low; bit0=a … bit6=g (0 → 7'b1000000).
- an_in  input  DIGITS  digit enables, active-low; bit i selects digit i. Digit 0 is the least-significant nibble.
- word_out  output  4*DIGITS  last completely captured word.
- word_valid  output  1  one-cycle pulse when word_out updates.
- err_pulse  output  1  one-cycle pulse on a rejected sample.
- err_code  output  2  01 = illegal segment pattern, 10 = illegal enable (more than one digit low). Held until the next error.
- err_digit  output  clog2(DIGITS)  digit index of the last pattern error; 0 for enable errors.
- busy  output  1  high while any digit of the current frame has been captured.

Behaviour:
- Reset (async assert): word_out=0, word_valid=0, err_pulse=0, err_code=00, err_digit=0, busy=0.
  - Capture mask and shadow nibbles cleared.
  - Synchronizer flops set to all-ones (idle lines).
  - Stability counter = 0; FSM = SETTLE.
- Input path: two-flop synchronizer on {seg_in, an_in}. The sample S is the second-stage value. P is S delayed by one cycle.
- FSM SETTLE:
  - If S != P, counter := 0.
  - Otherwise counter increments.
  - When counter reaches STABLE_CYCLES-1 with S == P, an accept event fires that cycle and the FSM goes to HOLD.
- FSM HOLD:
  - Stays while S == P; no further accept events.
  - When S != P, go to SETTLE with counter := 0.
  - Guarantees exactly one accept per stable period. Glitches shorter than STABLE_CYCLES are ignored.
- Accept event classification, first match wins:
  - an all ones: blanking; ignore.
  - an has more than one zero: err_pulse, err_code=10, err_digit=0; mask cleared (frame aborted).
  - seg == 7'b1111111: blank digit; ignore, no error.
  - seg matches one of the 16 encoder patterns: shadow[i] := nibble and mask[i] := 1. A repeated digit overwrites (latest wins).
  - Any other seg: err_pulse, err_code=01, err_digit=i; mask cleared.
- Completion: on the cycle after mask becomes all-ones:
  - word_out := shadow concatenation (digit DIGITS-1 in the MSBs).
  - word_valid pulses for 1 cycle.
  - mask := 0.
- Latency: with pins held stable from cycle t, the accept fires at t+1+STABLE_CYCLES. For the completing digit, word_valid is high at t+2+STABLE_CYCLES.
- busy = |mask.
- Simultaneous events: completion and a new accept cannot occur in the same cycle, because the minimum stable period exceeds 1 cycle. An error accept clears the mask even if the frame is 1 digit from complete.
- Reset mid-frame discards partial captures. word_out returns to 0.
- Counter saturates at STABLE_CYCLES-1; it never wraps.

Decomposition:
- Package seg7_pkg holds:
  - The 16 segment-pattern constants and SEG_BLANK = 7'h7F.
  - Error-code constants ERR_NONE, ERR_PATTERN, ERR_ENABLE.
  - The FSM state enum {SETTLE, HOLD}.
- Sub-module seg7_to_hex: combinational reverse lookup with inputs seg[6:0] and outputs nibble[3:0], is_digit, is_blank. It uses the package constants so that encoder and decoder share one table.

Test Plan:
- 0x1A2F frame: hold each digit 20 cycles in this order:
  - an=1110 with F 0001110
  - an=1101 with 2 0100100
  - an=1011 with A 0001000
  - an=0111 with 1 1111001
  - Required: word_out=16'h1A2F; word_valid high exactly 1 cycle, STABLE_CYCLES+2 cycles after the last change; busy low afterwards; no err_pulse.
- Glitch: a 5-cycle pulse of seg=0000000 on digit 0 inside a stable window (STABLE_CYCLES=8) → no accept, no error, mask unchanged.
- Bad pattern: digits 0 and 1 valid, then digit 2 with 0111111 → err_pulse 1 cycle, err_code=01, err_digit=2, busy=0, no word_valid until a fresh full frame.
- Enable error: an=1100 with a valid pattern → err_code=10, err_digit=0, mask cleared. Blank seg=1111111 on an=1110 → no error, no capture.
- Overwrite/reset:
  - Digit 0 sent as 3, then 7, then digits 1-3 → word_out nibble0=7.
  - Separately, assert rst_n low mid-frame → all outputs 0 asynchronously. After release, a full frame decodes correctly.
